// File: rtl/md5_rr_scheduler.sv
// md5_rr_scheduler: round-robin front end that shares one md5 core and sequences each job
// (clear, start, wait, respond). Define MD5_SCHED_TIMEOUT_EN to add a watchdog in WAIT.
module md5_rr_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*512-1:0] req_msg,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [127:0]           resp_digest,
  output logic                   resp_err,
  output logic                   core_reset,
  output logic                   core_start,
  output logic [511:0]           core_message,
  input  logic [127:0]           core_digest,
  input  logic                   core_ready
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam int SLOTS = 1 << ID_W;
  localparam logic [ID_W:0] NUM_REQ_X = NUM_REQ[ID_W:0];

  if (NUM_REQ < 2 || NUM_REQ > 8 || SLOTS < NUM_REQ || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("md5_rr_scheduler: illegal NUM_REQ / ID_W / TIMEOUT_CYCLES combination");
  end

  logic [2:0]      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [511:0]    core_message_q, core_message_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;
  logic [127:0]    resp_digest_q, resp_digest_d;
  logic            resp_valid_q, resp_valid_d;

`ifdef MD5_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            resp_err_q, resp_err_d;
`endif

  // Requests and blocks padded to a power-of-two table so an ID_W-bit index is always in range.
  logic [SLOTS-1:0] valid_slots;
  logic [511:0]     slot_msg [SLOTS];
  assign valid_slots = SLOTS'(req_valid);

  genvar gi;
  for (gi = 0; gi < SLOTS; gi++) begin : g_slot
    if (gi < NUM_REQ) begin : g_used
      assign slot_msg[gi] = req_msg[gi*512 +: 512];
    end else begin : g_unused
      assign slot_msg[gi] = '0;
    end
  end

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input logic [ID_W-1:0] off);
    logic [ID_W:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= NUM_REQ_X) sum = sum - NUM_REQ_X;
    return sum[ID_W-1:0];
  endfunction

  logic            grant_found;
  logic [ID_W-1:0] grant_idx, grant_next, cand;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap_add(rr_ptr_q, ID_W'(k));
      if (!grant_found && valid_slots[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    grant_next = wrap_add(grant_idx, ID_W'(1));
  end

  logic grant_ok;
  assign grant_ok = !reset && (state_q == ST_IDLE) && grant_found;

  for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = grant_ok && (grant_idx == ID_W'(gi));
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    core_message_d = core_message_q;
    resp_id_d      = resp_id_q;
    resp_digest_d  = resp_digest_q;
    resp_valid_d   = resp_valid_q;
`ifdef MD5_SCHED_TIMEOUT_EN
    wait_cnt_d     = wait_cnt_q;
    resp_err_d     = resp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          core_message_d = slot_msg[grant_idx];
          resp_id_d      = grant_idx;
          rr_ptr_d       = grant_next;
          state_d        = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_START;
      ST_START: begin
        state_d = ST_WAIT;
`ifdef MD5_SCHED_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (core_ready) begin
          resp_digest_d = core_digest;
          resp_valid_d  = 1'b1;
          state_d       = ST_RESP;
        end
`ifdef MD5_SCHED_TIMEOUT_EN
        // Watchdog: report an error response instead of hanging on a dead core.
        else if (wait_cnt_q == TO_LAST) begin
          resp_digest_d = '0;
          resp_err_d    = 1'b1;
          resp_valid_d  = 1'b1;
          state_d       = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
`endif
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
`ifdef MD5_SCHED_TIMEOUT_EN
          resp_err_d   = 1'b0;
`endif
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      core_message_q <= '0;
      resp_id_q      <= '0;
      resp_digest_q  <= '0;
      resp_valid_q   <= 1'b0;
`ifdef MD5_SCHED_TIMEOUT_EN
      wait_cnt_q     <= '0;
      resp_err_q     <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      core_message_q <= core_message_d;
      resp_id_q      <= resp_id_d;
      resp_digest_q  <= resp_digest_d;
      resp_valid_q   <= resp_valid_d;
`ifdef MD5_SCHED_TIMEOUT_EN
      wait_cnt_q     <= wait_cnt_d;
      resp_err_q     <= resp_err_d;
`endif
    end
  end

  // Core is held in reset alongside the scheduler so no stale job survives a reset.
  assign core_reset   = reset | (state_q == ST_CLEAR);
  assign core_start   = !reset && (state_q == ST_START);
  assign core_message = core_message_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_digest  = resp_digest_q;
`ifdef MD5_SCHED_TIMEOUT_EN
  assign resp_err     = resp_err_q;
`else
  assign resp_err     = 1'b0;
`endif

endmodule

// File: doc/md5_rr_scheduler.md
Name: md5_rr_scheduler

Overview:
- Shares one md5 core between NUM_REQ requesters using round-robin arbitration, and sequences every job on that core.
- Per job: latches the winning 512-bit block, pulses core reset to restore the initial chaining values, issues a one-cycle start, waits for core ready, and returns the digest with the requester ID on a valid/ready response bus.
- Sits between the message-block producers (padding units, host interface) and the single md5 datapath instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must satisfy 2**ID_W >= NUM_REQ.
- TIMEOUT_CYCLES, 128, watchdog limit in WAIT state; used only with MD5_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester job request
- req_msg  in  NUM_REQ*512  flattened blocks; requester i at [i*512 +: 512]; first message byte at bit [511:504] of each slice
- req_ready  out  NUM_REQ  one-hot accept pulse; block is captured on this cycle
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_id  out  ID_W  requester that owns the response
- resp_digest  out  128  MD5 digest, byte order as produced by core
- resp_err  out  1  watchdog expiry flag (always 0 without the macro)
- core_reset  out  1  drives core reset
- core_start  out  1  drives core start
- core_message  out  512  drives core message
- core_digest  in  128  from core
- core_ready  in  1  from core; sticky until core reset

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_id=0, resp_digest=0, resp_err=0, core_start=0, core_message=0, rr_ptr=0, state=IDLE.
- core_reset = reset OR (state==CLEAR), so the core is also cleared during scheduler reset.
- FSM IDLE -> CLEAR -> START -> WAIT -> RESP -> IDLE.
- IDLE: if any req_valid, grant the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - On grant: req_ready[g]=1 for exactly one cycle; latch the block into core_message; latch g into resp_id; set rr_ptr=(g+1) mod NUM_REQ; go to CLEAR.
  - If no req_valid, stay in IDLE.
- CLEAR: one cycle; core_reset=1. Reinitialises core chaining values and clears sticky ready. Go to START.
- START: one cycle; core_start=1 with core_message stable. Go to WAIT.
- WAIT: core_message held. When core_ready=1, capture core_digest into resp_digest, set resp_valid=1, go to RESP.
  - core_ready is ignored in CLEAR and START.
- RESP: hold resp_valid and all response fields stable until resp_ready=1.
  - The handshake cycle clears resp_valid and returns to IDLE.
  - A new grant occurs no earlier than the following cycle.
- Grant-to-start latency is exactly 2 cycles. Core compute is nominally 66 cycles, so grant-to-resp_valid is about 68 cycles.
- At most one job is in flight. req_ready stays 0 for all requesters outside IDLE.
- Requesters keep req_valid and req_msg stable until granted. Dropping req_valid before grant is legal and does not create a job.
- Fairness: a requester that stays valid is served within NUM_REQ jobs.
- Reset mid-operation (any state): the job is abandoned, no response is produced, rr_ptr returns to 0, and the core is reset.
- resp_ready asserted while resp_valid=0 has no effect.

Optional Feature:
- Macro: MD5_SCHED_TIMEOUT_EN.
- Defined:
  - A counter of at least $clog2(TIMEOUT_CYCLES+1) bits clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without core_ready, go to RESP with resp_err=1 and resp_digest=0.
  - resp_err clears when that response is accepted.
  - A late core_ready is discarded; CLEAR on the next job resets the core.
- Undefined: no counter; WAIT waits indefinitely; resp_err is tied to 0.

Test Plan:
- Single job: requester 1 sends padded "abc" block (512'h61626380_0…_18000000_00000000) with resp_ready=1 → one req_ready[1] pulse, core_start 2 cycles later, resp_id=1, resp_digest=128'h900150983cd24fb0d6963f7d28e17f72, resp_err=0.
- Round-robin: all 4 requesters held valid from reset → grant order 0,1,2,3,0. Each response carries the correct id; empty-message blocks give d41d8cd98f00b204e9800998ecf8427e.
- Back-pressure: resp_ready=0 for 20 cycles after resp_valid → outputs stable, no new req_ready, core_start not reasserted; job proceeds after the handshake.
- Back-to-back chaining isolation: "abc" then empty message from the same requester → second digest d41d8cd98f00b204e9800998ecf8427e, proving CLEAR restores the initial chaining values.
- Reset in WAIT after 30 cycles → no resp_valid; next grant goes to requester 0; core_reset high during reset.
- With MD5_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, core_ready forced 0 → resp_valid 16 cycles after WAIT entry with resp_err=1 and resp_digest=0.
